pos_equiv_scanner: RTL and testbench



---
 rtl/pos_equiv_pkg.sv | 15 +
 rtl/pos_equiv_scanner_settle_timer.sv | 28 ++
 rtl/pos_equiv_scanner.sv | 148 ++++++++++++++
 tb/tb_pos_equiv_scanner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_equiv_pkg.sv
// Shared definitions for the SOP/POS equivalence scanner.
package pos_equiv_pkg;

  localparam int unsigned MINTERMS   = 16;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FIN
  } state_e;

endpackage

// File: rtl/pos_equiv_scanner_settle_timer.sv
// Settle timer: loadable 4-bit down-counter; expired_o is high while the count is zero.
module settle_timer
  import pos_equiv_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [IDX_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [IDX_W-1:0] cnt_q;

  // Load takes priority; otherwise count down to zero and stop there.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pos_equiv_scanner.sv
// Equivalence scanner: sweeps a,b,c,d through all minterms, samples the SOP
// and POS implementations after a settle time, and compares the truth tables.
// Optional feature macro: POS_EQUIV_FAIL_IDX_EN adds the fail_idx output.
module pos_equiv_scanner
  import pos_equiv_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_s,
  input  logic        f_p,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        equal,
  output logic [15:0] tt_s,
  output logic [15:0] tt_p
`ifdef POS_EQUIV_FAIL_IDX_EN
  ,
  output logic [3:0]  fail_idx
`endif
);

  // Timer counts SETTLE_CYC-1 down to 0, giving SETTLE_CYC cycles in SETTLE.
  // Out-of-range settings are clamped into 1..SETTLE_MAX.
  localparam int unsigned SETTLE_EFF =
    (SETTLE_CYC == 0) ? 1 : ((SETTLE_CYC > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYC);
  localparam logic [IDX_W-1:0] SETTLE_LOAD = IDX_W'(SETTLE_EFF - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(MINTERMS - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 equal_q;
  logic [MINTERMS-1:0]  tt_s_q, tt_s_d;
  logic [MINTERMS-1:0]  tt_p_q, tt_p_d;
  logic                 timer_load;
  logic                 timer_en;
  logic                 timer_expired;
`ifdef POS_EQUIV_FAIL_IDX_EN
  logic [IDX_W-1:0]     fail_idx_q;
`endif

  // Timer is reloaded while idle or sampling so every SETTLE starts full.
  always_comb begin
    timer_load = (state_q == IDLE) || (state_q == SAMPLE);
    timer_en   = (state_q == SETTLE);
  end

  settle_timer u_settle_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (timer_load),
    .load_val_i (SETTLE_LOAD),
    .en_i       (timer_en),
    .expired_o  (timer_expired)
  );

  // Truth tables with the current minterm's sample merged in.
  always_comb begin
    tt_s_d        = tt_s_q;
    tt_p_d        = tt_p_q;
    tt_s_d[idx_q] = f_s;
    tt_p_d[idx_q] = f_p;
  end

  // Scan FSM with registered outputs and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      equal_q    <= 1'b0;
      tt_s_q     <= '0;
      tt_p_q     <= '0;
`ifdef POS_EQUIV_FAIL_IDX_EN
      fail_idx_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            tt_s_q     <= '0;
            tt_p_q     <= '0;
            equal_q    <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b1;
`ifdef POS_EQUIV_FAIL_IDX_EN
            fail_idx_q <= '0;
`endif
            state_q    <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_expired) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          tt_s_q <= tt_s_d;
          tt_p_q <= tt_p_d;
`ifdef POS_EQUIV_FAIL_IDX_EN
          // Equal tables so far means no earlier mismatch: this one is the first.
          if ((f_s != f_p) && (tt_s_q == tt_p_q)) begin
            fail_idx_q <= idx_q;
          end
`endif
          if (idx_q == LAST_IDX) begin
            // Compare against the merged tables so bit 15 is included.
            equal_q <= (tt_s_d == tt_p_d);
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= SETTLE;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign {a, b, c, d} = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign equal        = equal_q;
  assign tt_s         = tt_s_q;
  assign tt_p         = tt_p_q;
`ifdef POS_EQUIV_FAIL_IDX_EN
  assign fail_idx     = fail_idx_q;
`endif

endmodule

// File: tb/tb_pos_equiv_scanner.sv
// Self-checking bench for pos_equiv_scanner (SETTLE_CYC=1 and SETTLE_CYC=3 instances).
module tb_pos_equiv_scanner;

  logic        clk = 1'b0;
  logic        rst, start, sel3;
  logic [15:0] tab_s, tab_p;

  logic        start1, start3, fs1, fp1, fs3, fp3;
  logic        a1, b1, c1, d1, busy1, done1, equal1;
  logic        a3, b3, c3, d3, busy3, done3, equal3;
  logic [15:0] tts1, ttp1, tts3, ttp3;
  logic [3:0]  fi1, fi3;

  logic [3:0]  o_abcd;
  logic        o_busy, o_done, o_equal;
  logic [15:0] o_tts, o_ttp;
  logic [3:0]  o_fi;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // External SOP/POS logic modelled as truth-table lookups on the driven minterm.
  assign start1 = start & ~sel3;
  assign start3 = start & sel3;
  assign fs1 = tab_s[{a1, b1, c1, d1}];
  assign fp1 = tab_p[{a1, b1, c1, d1}];
  assign fs3 = tab_s[{a3, b3, c3, d3}];
  assign fp3 = tab_p[{a3, b3, c3, d3}];

  assign o_abcd  = sel3 ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
  assign o_busy  = sel3 ? busy3  : busy1;
  assign o_done  = sel3 ? done3  : done1;
  assign o_equal = sel3 ? equal3 : equal1;
  assign o_tts   = sel3 ? tts3   : tts1;
  assign o_ttp   = sel3 ? ttp3   : ttp1;
`ifdef POS_EQUIV_FAIL_IDX_EN
  assign o_fi    = sel3 ? fi3    : fi1;
`else
  assign fi1  = '0;
  assign fi3  = '0;
  assign o_fi = '0;
`endif

  pos_equiv_scanner #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f_s(fs1), .f_p(fp1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .equal(equal1), .tt_s(tts1), .tt_p(ttp1)
`ifdef POS_EQUIV_FAIL_IDX_EN
    , .fail_idx(fi1)
`endif
  );

  pos_equiv_scanner #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .f_s(fs3), .f_p(fp3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .equal(equal3), .tt_s(tts3), .tt_p(ttp3)
`ifdef POS_EQUIV_FAIL_IDX_EN
    , .fail_idx(fi3)
`endif
  );

  // Reference: lowest minterm where the two tables disagree, 0 if none.
  function automatic logic [3:0] ref_fail_idx(input logic [15:0] ts, input logic [15:0] tp);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (ts[i] != tp[i]) r = 4'(i);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset-value check on whichever DUT is selected.
  task automatic check_reset_vals(input string name);
    logic [38:0] got;
    got = {o_abcd, o_busy, o_done, o_equal, o_tts, o_ttp};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s reset outputs: got abcd=%h busy=%b done=%b equal=%b tt_s=%h tt_p=%h, want all 0",
               name, o_abcd, o_busy, o_done, o_equal, o_tts, o_ttp);
    end
`ifdef POS_EQUIV_FAIL_IDX_EN
    checks++;
    if (o_fi !== 4'd0) begin
      errors++;
      $display("FAIL %s reset fail_idx: got %0d want 0", name, o_fi);
    end
`endif
  endtask

  // One scan, checked cycle by cycle. Cycle 0 is the edge that samples start.
  task automatic do_scan(input bit use3, input logic [15:0] ts, input logic [15:0] tp,
                         input bit repulse, input bit hold, input int unsigned rst_at,
                         input string name);
    int unsigned s, per, last;
    logic [3:0]  exp_abcd;
    logic        exp_eq;
    logic [3:0]  exp_fi;
    s      = use3 ? 3 : 1;
    per    = s + 1;
    last   = 1 + 16 * per;
    exp_eq = (ts == tp);
    exp_fi = ref_fail_idx(ts, tp);
    sel3   = use3;
    tab_s  = ts;
    tab_p  = tp;
    start  = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int unsigned n = 1; n <= last; n++) begin
      if (repulse && (n == 5 || n == 20)) start = 1'b1;
      else if (!hold) start = 1'b0;
      exp_abcd = (n == last) ? 4'd15 : 4'((n - 1) / per);
      checks++;
      if (o_abcd !== exp_abcd) begin
        errors++;
        $display("FAIL %s abcd cyc %0d: got %h want %h", name, n, o_abcd, exp_abcd);
      end
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cyc %0d: got %b want 1", name, n, o_busy);
      end
      checks++;
      if (o_done !== (n == last)) begin
        errors++;
        $display("FAIL %s done cyc %0d: got %b want %b", name, n, o_done, (n == last));
      end
      if (n == 1) begin
        checks++;
        if ({o_equal, o_tts, o_ttp} !== '0) begin
          errors++;
          $display("FAIL %s cleared at cyc 1: got equal=%b tt_s=%h tt_p=%h want 0", name, o_equal, o_tts, o_ttp);
        end
      end
      if (n == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals({name, " mid-scan"});
        return;
      end
      if (n == last) begin
        checks++;
        if (o_tts !== ts || o_ttp !== tp) begin
          errors++;
          $display("FAIL %s tables at done: got tt_s=%h tt_p=%h want %h %h", name, o_tts, o_ttp, ts, tp);
        end
        checks++;
        if (o_equal !== exp_eq) begin
          errors++;
          $display("FAIL %s equal at done: got %b want %b", name, o_equal, exp_eq);
        end
`ifdef POS_EQUIV_FAIL_IDX_EN
        checks++;
        if (o_fi !== exp_fi) begin
          errors++;
          $display("FAIL %s fail_idx: got %0d want %0d", name, o_fi, exp_fi);
        end
`endif
      end
      tick();
    end
    // First IDLE cycle: busy drops, results and minterm hold.
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got busy=%b done=%b want 0 0", name, o_busy, o_done);
    end
    checks++;
    if (o_tts !== ts || o_ttp !== tp || o_equal !== exp_eq || o_abcd !== 4'd15) begin
      errors++;
      $display("FAIL %s held results: got tt_s=%h tt_p=%h eq=%b abcd=%h want %h %h %b f",
               name, o_tts, o_ttp, o_equal, o_abcd, ts, tp, exp_eq);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    sel3 = 1'b0;
    tab_s = '0;
    tab_p = '0;
    tick();
    tick();
    rst = 1'b0;
    sel3 = 1'b0;
    #0 check_reset_vals("reset dut1");
    sel3 = 1'b1;
    #0 check_reset_vals("reset dut3");
  endtask

  task automatic test_reference();
    do_scan(1'b0, 16'hAAE0, 16'hAAE0, 1'b0, 1'b0, 0, "reference");
  endtask

  task automatic test_missing_minterm();
    do_scan(1'b0, 16'hAAA0, 16'hAAE0, 1'b0, 1'b0, 0, "missing_m6");
  endtask

  task automatic test_settle3();
    do_scan(1'b1, 16'hAAE0, 16'hAAE0, 1'b0, 1'b0, 0, "settle3");
    do_scan(1'b1, 16'h1234, 16'h1634, 1'b0, 1'b0, 0, "settle3_mis");
  endtask

  task automatic test_start_ignored();
    do_scan(1'b0, 16'hAAE0, 16'hAAE0, 1'b1, 1'b0, 0, "start_ignored");
  endtask

  task automatic test_mid_reset();
    do_scan(1'b0, 16'h00FF, 16'h00F0, 1'b0, 1'b0, 10, "mid_reset");
    repeat (3) tick();
    checks++;
    if (o_busy !== 1'b0 || o_abcd !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset idle: got busy=%b abcd=%h want 0 0", o_busy, o_abcd);
    end
    do_scan(1'b0, 16'hAAE0, 16'hAAE0, 1'b0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_const_mismatch();
    do_scan(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, "const_mis");
    do_scan(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, "const_second");
    do_scan(1'b0, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 0, "const_third");
  endtask

  task automatic test_back_to_back();
    do_scan(1'b1, 16'hF00F, 16'hF00F, 1'b0, 1'b1, 0, "b2b_first");
    do_scan(1'b1, 16'h8001, 16'h0001, 1'b0, 1'b0, 0, "b2b_second");
  endtask

  task automatic test_random();
    logic [15:0] ts, tp;
    bit          u3;
    for (int k = 0; k < 8; k++) begin
      ts = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       tp = ts;
        1:       tp = ts ^ (16'h1 << $urandom_range(0, 15));
        default: tp = 16'($urandom);
      endcase
      u3 = 1'($urandom_range(0, 1));
      do_scan(u3, ts, tp, 1'b0, 1'b0, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_missing_minterm();
    test_settle3();
    test_start_ignored();
    test_mid_reset();
    test_const_mismatch();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
